// File: rtl/md_issue_ctrl.sv
// Issue controller between EX and the HI/LO multiply-divide unit: decodes MD ops,
// pulses start/write controls and self-times each multiply/divide. Optional macro: MD_DIV0_SKIP_EN.
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [3:0]    req_op,
  input  logic [DW-1:0] rs_val,
  input  logic [DW-1:0] rt_val,
  input  logic          flush,
  output logic          stall,
  output logic          md_start,
  output logic          md_op,
  output logic          md_sign,
  output logic          md_we,
  output logic          md_write_sel,
  output logic [DW-1:0] md_a,
  output logic [DW-1:0] md_b,
  output logic [1:0]    mf_sel,
  output logic          busy_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            md_start_q, md_start_d;
  logic            md_op_q, md_op_d;
  logic            md_sign_q, md_sign_d;
  logic            md_we_q, md_we_d;
  logic            md_write_sel_q, md_write_sel_d;
  logic [DW-1:0]   md_a_q, md_a_d;
  logic [DW-1:0]   md_b_q, md_b_d;

  logic is_start, is_write, is_read, is_md, is_div;
  logic accept, start_acc, write_acc, div0_skip;

  assign is_start = (req_op >= OP_MULT) && (req_op <= OP_DIVU);
  assign is_write = (req_op == OP_MTHI) || (req_op == OP_MTLO);
  assign is_read  = (req_op == OP_MFHI) || (req_op == OP_MFLO);
  assign is_md    = is_start | is_write | is_read;
  assign is_div   = (req_op == OP_DIV) || (req_op == OP_DIVU);

  assign stall  = req_valid & is_md & (state_q != IDLE);
  assign accept = req_valid & ~stall & ~flush & (is_start | is_write);

`ifdef MD_DIV0_SKIP_EN
  // A zero divisor is swallowed: HI/LO stay as they are and nothing is timed.
  assign div0_skip = is_div & (rt_val == '0);
`else
  assign div0_skip = 1'b0;
`endif

  assign start_acc = accept & is_start & ~div0_skip;
  assign write_acc = accept & is_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      md_start_q     <= 1'b0;
      md_op_q        <= 1'b0;
      md_sign_q      <= 1'b0;
      md_we_q        <= 1'b0;
      md_write_sel_q <= 1'b0;
      md_a_q         <= '0;
      md_b_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      md_start_q     <= md_start_d;
      md_op_q        <= md_op_d;
      md_sign_q      <= md_sign_d;
      md_we_q        <= md_we_d;
      md_write_sel_q <= md_write_sel_d;
      md_a_q         <= md_a_d;
      md_b_q         <= md_b_d;
    end
  end

  // ISSUE holds the count; BUSY then runs LAT cycles, giving LAT+1 stall cycles in total.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = ISSUE;
          cnt_d   = is_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
        end
      end
      ISSUE: state_d = BUSY;
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    md_start_d     = start_acc;
    md_we_d        = write_acc;
    md_op_d        = md_op_q;
    md_sign_d      = md_sign_q;
    md_write_sel_d = md_write_sel_q;
    md_a_d         = md_a_q;
    md_b_d         = md_b_q;
    if (start_acc) begin
      md_op_d   = is_div;
      md_sign_d = (req_op == OP_MULT) || (req_op == OP_DIV);
      md_a_d    = rs_val;
      md_b_d    = rt_val;
    end
    if (write_acc) begin
      md_write_sel_d = (req_op == OP_MTLO);
      md_a_d         = rs_val;
    end
  end

  always_comb begin
    mf_sel = 2'b00;
    if (req_valid && !stall) begin
      if (req_op == OP_MFHI) begin
        mf_sel = 2'b01;
      end else if (req_op == OP_MFLO) begin
        mf_sel = 2'b10;
      end
    end
  end

  assign md_start     = md_start_q;
  assign md_op        = md_op_q;
  assign md_sign      = md_sign_q;
  assign md_we        = md_we_q;
  assign md_write_sel = md_write_sel_q;
  assign md_a         = md_a_q;
  assign md_b         = md_b_q;
  assign busy_dbg     = (state_q != IDLE);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    lat_legal_a: assert (MULT_LAT >= 1 && MULT_LAT <= 15 && DIV_LAT >= 1 && DIV_LAT <= 15)
      else $error("md_issue_ctrl: latency parameter outside 1..15");
  end
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: a stall-countdown model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_md_issue_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int DW       = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [3:0]    req_op;
  logic [DW-1:0] rs_val, rt_val;
  logic          flush;
  logic          stall, md_start, md_op, md_sign, md_we, md_write_sel, busy_dbg;
  logic [DW-1:0] md_a, md_b;
  logic [1:0]    mf_sel;

  int n_checks = 0;
  int n_fail   = 0;

  md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall),
    .md_start(md_start), .md_op(md_op), .md_sign(md_sign), .md_we(md_we),
    .md_write_sel(md_write_sel), .md_a(md_a), .md_b(md_b), .mf_sel(mf_sel),
    .busy_dbg(busy_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit f_md(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd8;
  endfunction

  int            rem;   // stall cycles still owed, counting the current one
  logic          e_start, e_we, e_op, e_sign, e_wsel;
  logic [DW-1:0] e_a, e_b;

  function automatic bit m_stall();
    return req_valid && f_md(req_op) && rem > 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem <= 0; e_start <= 1'b0; e_we <= 1'b0; e_op <= 1'b0; e_sign <= 1'b0;
      e_wsel <= 1'b0; e_a <= '0; e_b <= '0;
    end else begin
      bit acc, skip;
      acc  = req_valid && !m_stall() && !flush && req_op >= 4'd1 && req_op <= 4'd6;
      skip = 1'b0;
`ifdef MD_DIV0_SKIP_EN
      skip = (req_op == 4'd3 || req_op == 4'd4) && rt_val == '0;
`endif
      rem     <= (rem > 0) ? rem - 1 : 0;
      e_start <= 1'b0;
      e_we    <= 1'b0;
      if (acc && req_op <= 4'd4 && !skip) begin
        rem     <= ((req_op >= 4'd3) ? DIV_LAT : MULT_LAT) + 1;
        e_start <= 1'b1;
        e_op    <= (req_op >= 4'd3);
        e_sign  <= (req_op == 4'd1 || req_op == 4'd3);
        e_a     <= rs_val;
        e_b     <= rt_val;
      end
      if (acc && req_op >= 4'd5) begin
        e_we   <= 1'b1;
        e_wsel <= (req_op == 4'd6);
        e_a    <= rs_val;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      logic [1:0] e_mf;
      e_mf = 2'b00;
      if (req_valid && !m_stall()) e_mf = (req_op == 4'd7) ? 2'b01 : (req_op == 4'd8) ? 2'b10 : 2'b00;
      chk("stall",    32'(stall),        32'(m_stall()));
      chk("mf_sel",   32'(mf_sel),       32'(e_mf));
      chk("busy_dbg", 32'(busy_dbg),     32'(rem > 0));
      chk("md_start", 32'(md_start),     32'(e_start));
      chk("md_we",    32'(md_we),        32'(e_we));
      chk("md_op",    32'(md_op),        32'(e_op));
      chk("md_sign",  32'(md_sign),      32'(e_sign));
      chk("md_wsel",  32'(md_write_sel), 32'(e_wsel));
      chk("md_a",     md_a,              e_a);
      chk("md_b",     md_b,              e_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl);
    @(posedge clk);
    #1;
    req_valid = v; req_op = op; rs_val = rs; rt_val = rt; flush = fl;
  endtask

  // Called at a negedge; returns at the first negedge with stall low.
  task automatic count_stalls(output int n);
    n = 0;
    while (stall && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy_dbg && k < 40) begin
      k++;
      @(negedge clk);
    end
    chk("wait_idle", 32'(busy_dbg), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b0; req_valid = 1'b0; req_op = 4'd0; rs_val = '0; rt_val = '0; flush = 1'b0;
    @(negedge clk);
    chk("rst_start", 32'(md_start), 32'd0);
    chk("rst_busy",  32'(busy_dbg), 32'd0);
    chk("rst_a",     md_a,          32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // MULT 3 * -4, then MFLO held
    drive(1, 4'd1, 32'd3, 32'hFFFF_FFFC, 0);
    drive(1, 4'd8, 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("mult_start", 32'(md_start), 32'd1);
    chk("mult_sign",  32'(md_sign),  32'd1);
    chk("mult_op",    32'(md_op),    32'd0);
    chk("mult_b",     md_b,          32'hFFFF_FFFC);
    count_stalls(n);
    chk("mult_stalls", 32'(n), 32'd6);
    chk("mflo_sel",    32'(mf_sel), 32'd2);

    // DIVU 100/7, then DIV -50/3 held
    drive(1, 4'd4, 32'd100, 32'd7, 0);
    drive(1, 4'd3, 32'hFFFF_FFCE, 32'd3, 0);
    @(negedge clk);
    chk("divu_sign", 32'(md_sign), 32'd0);
    chk("divu_a",    md_a,         32'd100);
    count_stalls(n);
    chk("div_stalls", 32'(n), 32'd11);
    drive(0, 4'd0, 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("div_start", 32'(md_start), 32'd1);
    chk("div_op",    32'(md_op),    32'd1);
    chk("div_sign",  32'(md_sign),  32'd1);
    chk("div_a",     md_a,          32'hFFFF_FFCE);
    chk("div_b",     md_b,          32'd3);
    wait_idle();

    // MTHI from IDLE
    drive(1, 4'd5, 32'hDEAD_BEEF, 32'd0, 0);
    @(negedge clk);
    chk("mthi_stall", 32'(stall), 32'd0);
    drive(0, 4'd0, 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("mthi_we",   32'(md_we),        32'd1);
    chk("mthi_wsel", 32'(md_write_sel), 32'd0);
    chk("mthi_a",    md_a,              32'hDEAD_BEEF);
    @(negedge clk);
    chk("mthi_we_drop", 32'(md_we), 32'd0);

    // MTLO behind a MULT
    drive(1, 4'd2, 32'd1, 32'd1, 0);
    drive(1, 4'd6, 32'h0000_1234, 32'd0, 0);
    @(negedge clk);
    count_stalls(n);
    chk("mtlo_stalls", 32'(n), 32'd6);
    drive(0, 4'd0, 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("mtlo_we",   32'(md_we),        32'd1);
    chk("mtlo_wsel", 32'(md_write_sel), 32'd1);
    chk("mtlo_a",    md_a,              32'h0000_1234);

    // Flush: suppressed accept, then flush during BUSY
    drive(1, 4'd1, 32'd9, 32'd9, 1);
    drive(0, 4'd0, 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("flush_start", 32'(md_start), 32'd0);
    chk("flush_busy",  32'(busy_dbg), 32'd0);
    drive(1, 4'd1, 32'd2, 32'd2, 0);
    drive(1, 4'd1, 32'd9, 32'd9, 1);
    @(negedge clk);
    count_stalls(n);
    chk("flush_stalls", 32'(n), 32'd6);
    drive(0, 4'd0, 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("flush_idle", 32'(busy_dbg), 32'd0);
    chk("flush_a",    md_a,          32'd2);

    // Divide by zero, then MFHI held
    drive(1, 4'd3, 32'd5, 32'd0, 0);
    drive(1, 4'd7, 32'd0, 32'd0, 0);
    @(negedge clk);
`ifdef MD_DIV0_SKIP_EN
    chk("div0_start", 32'(md_start), 32'd0);
    count_stalls(n);
    chk("div0_stalls", 32'(n), 32'd0);
`else
    chk("div0_start", 32'(md_start), 32'd1);
    count_stalls(n);
    chk("div0_stalls", 32'(n), 32'd11);
`endif
    chk("div0_mfhi", 32'(mf_sel), 32'd1);
    drive(0, 4'd0, 32'd0, 32'd0, 0);

    // Reset asserted mid-operation
    drive(1, 4'd1, 32'd7, 32'd8, 0);
    drive(1, 4'd7, 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall),    32'd0);
    chk("mid_rst_busy",  32'(busy_dbg), 32'd0);
    chk("mid_rst_start", 32'(md_start), 32'd0);
    chk("mid_rst_sign",  32'(md_sign),  32'd0);
    chk("mid_rst_b",     md_b,          32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", 32'(stall),  32'd0);
    chk("post_rst_mf",    32'(mf_sel), 32'd1);
    drive(0, 4'd0, 32'd0, 32'd0, 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Issue/scheduling controller that sits between the EX stage and the HI/LO multiply-divide unit.
- Decodes the EX-stage MD operation and drives the unit's start/op/sign/write-enable controls with single-cycle pulses.
- Self-times each multiply or divide with a latency counter.
- Raises a pipeline stall when an MD-class instruction arrives while an earlier multiply or divide is still in flight.

Parameters:
- MULT_LAT, 5, busy cycles after the start pulse for MULT/MULTU (legal range 1..15)
- DIV_LAT, 10, busy cycles after the start pulse for DIV/DIVU (legal range 1..15)
- DW, 32, operand width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- req_valid  in  1  EX stage holds an MD-class instruction
- req_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 treated as NONE
- rs_val  in  DW  forwarded rs operand
- rt_val  in  DW  forwarded rt operand
- flush  in  1  EX instruction cancelled (exception or branch squash)
- stall  out  1  freeze IF/ID/EX this cycle (combinational)
- md_start  out  1  one-cycle start pulse to the unit (registered)
- md_op  out  1  0 = multiply, 1 = divide (registered)
- md_sign  out  1  1 = signed (registered)
- md_we  out  1  one-cycle HI/LO write pulse (registered)
- md_write_sel  out  1  0 = HI, 1 = LO (registered)
- md_a  out  DW  operand A latched at accept (registered)
- md_b  out  DW  operand B latched at accept (registered)
- mf_sel  out  2  00 none, 01 HI, 10 LO; combinational, for the EX result mux
- busy_dbg  out  1  1 when state is not IDLE

Behaviour:
- Reset: when reset is 0, asynchronously force state=IDLE, cnt=0, and drive every registered output to 0.
- Classes: MULT/MULTU/DIV/DIVU are "start" ops; MTHI/MTLO are "write" ops; MFHI/MFLO are "read" ops. All three classes count as MD-class.
- stall = req_valid & MD-class(req_op) & (state != IDLE). It does not depend on flush.
- accept = req_valid & ~stall & ~flush & (req_op in 1..6).
- Read ops never change state. When req_valid is 1 and there is no stall, mf_sel shows HI or LO; otherwise mf_sel = 00.
- State machine:
  - IDLE: on accept of a start op, latch md_a=rs_val and md_b=rt_val, drive md_op/md_sign per the op (MULT and DIV are signed), pulse md_start, load cnt=LAT, and go to ISSUE.
  - IDLE: on accept of a write op, latch md_a=rs_val, set md_write_sel, pulse md_we for one cycle, and stay in IDLE.
  - ISSUE (the cycle md_start is high): md_start drops next edge; go to BUSY.
  - BUSY: decrement cnt each cycle; when cnt reaches 1, go to IDLE.
- Timing: for a start op accepted at edge T, stall is high for every dependent MD-class request from T through T+LAT inclusive (LAT+1 cycles). Non-MD instructions never stall.
- md_we is issued only from IDLE, so a write never overlaps an in-flight operation and the unit's "write only when not busy" rule always holds.
- md_op, md_sign, md_a, md_b hold their values until the next accept. md_start and md_we are 0 in all other cycles.
- Flush:
  - Flush suppresses acceptance in the same cycle.
  - Flush does not abort an in-flight op, because the unit has no abort.
  - A flushed request in BUSY still sees stall=1 and is dropped.
- Reset mid-operation: immediate return to IDLE; the unit is reset by the same signal.
- Illegal LAT values (0 or >15): covered by a simulation-only assertion.

Optional Feature:
- Macro: MD_DIV0_SKIP_EN.
- Defined: DIV/DIVU with rt_val==0 is accepted with no md_start pulse and no state change; HI/LO remain unchanged and no stall is generated.
- Undefined: divide-by-zero is issued like any other divide, with DIV_LAT busy cycles; the result is whatever the unit produces.

Test Plan:
- Reset: hold reset=0 mid-BUSY, then release → all outputs 0, state IDLE, stall=0.
- MULT then MFLO: MULT (rs=3, rt=-4) accepted at T, then MFLO held valid → md_start=1 at T+1 only, md_sign=1, md_op=0; stall=1 for cycles T..T+5; mf_sel=10 at T+6.
- DIVU then DIV back-to-back: DIVU (rs=100, rt=7) then DIV held → second op stalls 11 cycles, then md_start pulses with md_op=1, md_sign=1, md_a/md_b taken from the second op.
- MTHI: MTHI rs=0xDEADBEEF from IDLE → md_we=1 for one cycle, md_write_sel=0, md_a=0xDEADBEEF, stall=0. MTLO during BUSY → stalled until IDLE, then md_we pulses with md_write_sel=1.
- Flush: MULT with flush=1 → no md_start, state stays IDLE. Flush during BUSY → the counter completes unchanged.
- Divide by zero: DIV rt=0 → with MD_DIV0_SKIP_EN, no md_start and stall=0 on the next MFHI; without it, md_start pulses and 11 stall cycles follow.
